// File: rtl/alu_issue_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_pkg
//   Shared types and constants for the ALU issue queue.
//   - state_t   : issue/retire FSM states (IDLE, EXEC, RESULT)
//   - SEL_W     : width of the ALU operation select
//   - cmd_t     : command record {s, x, y, cin}; operands are declared at
//                 OPND_W_MAX and a queue instance uses the low WIDTH bits
//   - cmd_bits(): packed width of one queued command for a given WIDTH,
//                 used to size the FIFO payload
// ---------------------------------------------------------------------------
package alu_issue_pkg;

  localparam int SEL_W      = 2;
  localparam int OPND_W_MAX = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0]      s;
    logic [OPND_W_MAX-1:0] x;
    logic [OPND_W_MAX-1:0] y;
    logic                  cin;
  } cmd_t;

  // Payload layout in the FIFO is {s, x, y, cin} with WIDTH-bit operands.
  function automatic int cmd_bits(input int width);
    return SEL_W + 2 * width + 1;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
//   Synchronous command FIFO for the ALU issue queue. Pointers wrap modulo
//   DEPTH (DEPTH is a power of two); occupancy is tracked in a separate
//   clog2(DEPTH)+1 bit counter so full and empty are unambiguous. There is
//   no write-to-read bypass: an entry written at one edge becomes visible at
//   rdata_o/empty_o only after that edge.
//
//   Parameters : DW    payload width in bits
//                DEPTH number of entries (power of two, >= 2)
//   Ports      : clk, rst      clock, asynchronous active-high reset
//                push_i        write wdata_i (ignored when full)
//                wdata_i       payload to write
//                pop_i         drop head entry (ignored when empty)
//                rdata_o       head entry
//                empty_o       no entries held
//                full_o        DEPTH entries held
// ---------------------------------------------------------------------------
module alu_cmd_fifo
  import alu_issue_pkg::*;
#(
  parameter int DW    = 13,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries data only; emptiness comes from count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_issue_queue.sv
// ---------------------------------------------------------------------------
// alu_issue_queue
//   Buffers ALU commands in a FIFO and issues them one at a time to an
//   external combinational ALU. Each issued command gets exactly one cycle
//   of ALU settle time (EXEC) before its result is captured and offered on
//   a valid/ready result port (RESULT). Throughput is one result per two
//   cycles when the consumer is always ready.
//
//   Optional feature: define ALU_ISSUE_STATS_EN to add op_count, an 8-bit
//   saturating count of result handshakes.
//
//   Parameters : WIDTH  operand/result width
//                DEPTH  command FIFO entries (power of two, >= 2)
//   Ports      : clk, rst                    clock, async active-high reset
//                cmd_valid/cmd_ready         command handshake
//                cmd_s, cmd_x, cmd_y, cmd_cin command fields
//                alu_s, alu_x, alu_y, alu_cin registered ALU drive
//                alu_f, alu_cout             ALU result inputs
//                res_valid/res_ready         result handshake
//                res_f, res_cout, res_s      captured result and op tag
//                op_count                    (ALU_ISSUE_STATS_EN only)
// ---------------------------------------------------------------------------
module alu_issue_queue
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_s,
  input  logic [WIDTH-1:0] cmd_x,
  input  logic [WIDTH-1:0] cmd_y,
  input  logic             cmd_cin,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [SEL_W-1:0] alu_s,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_f,
  output logic             res_cout,
  output logic [SEL_W-1:0] res_s
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [7:0]       op_count
`endif
);

  localparam int CW = cmd_bits(WIDTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_issue_queue: DEPTH must be a power of two and at least 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_x_q, alu_x_d;
  logic [WIDTH-1:0] alu_y_q, alu_y_d;
  logic [SEL_W-1:0] alu_s_q, alu_s_d;
  logic             alu_cin_q, alu_cin_d;
  logic [WIDTH-1:0] res_f_q, res_f_d;
  logic             res_cout_q, res_cout_d;
  logic [SEL_W-1:0] res_s_q, res_s_d;
  logic             res_valid_q, res_valid_d;

  logic [CW-1:0]    push_data;
  logic [CW-1:0]    head;
  logic             fifo_empty, fifo_full;
  logic             pop;
  logic             capture;

  // cmd_ready depends only on registered occupancy, so a pop in the same
  // cycle never opens a slot for a push.
  assign cmd_ready = !fifo_full;
  assign push_data = {cmd_s, cmd_x, cmd_y, cmd_cin};

  alu_cmd_fifo #(
    .DW    (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid && cmd_ready),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    res_valid_d = res_valid_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture     = 1'b1;
        res_valid_d = 1'b1;
        state_d     = RESULT;
      end
      RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // ALU drive holds the last issued command; result holds the last capture.
  always_comb begin
    alu_s_d    = alu_s_q;
    alu_x_d    = alu_x_q;
    alu_y_d    = alu_y_q;
    alu_cin_d  = alu_cin_q;
    res_f_d    = res_f_q;
    res_cout_d = res_cout_q;
    res_s_d    = res_s_q;
    if (pop) begin
      alu_s_d   = head[CW-1 -: SEL_W];
      alu_x_d   = head[2*WIDTH : WIDTH+1];
      alu_y_d   = head[WIDTH : 1];
      alu_cin_d = head[0];
    end
    if (capture) begin
      res_f_d    = alu_f;
      res_cout_d = alu_cout;
      res_s_d    = alu_s_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_s_q     <= '0;
      alu_x_q     <= '0;
      alu_y_q     <= '0;
      alu_cin_q   <= 1'b0;
      res_f_q     <= '0;
      res_cout_q  <= 1'b0;
      res_s_q     <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_s_q     <= alu_s_d;
      alu_x_q     <= alu_x_d;
      alu_y_q     <= alu_y_d;
      alu_cin_q   <= alu_cin_d;
      res_f_q     <= res_f_d;
      res_cout_q  <= res_cout_d;
      res_s_q     <= res_s_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign alu_s     = alu_s_q;
  assign alu_x     = alu_x_q;
  assign alu_y     = alu_y_q;
  assign alu_cin   = alu_cin_q;
  assign res_f     = res_f_q;
  assign res_cout  = res_cout_q;
  assign res_s     = res_s_q;
  assign res_valid = res_valid_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [7:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (res_valid_q && res_ready && op_count_q != 8'hFF) op_count_d = op_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= 8'd0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;

  localparam int WIDTH = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_s = '0;
  logic [WIDTH-1:0] cmd_x = '0;
  logic [WIDTH-1:0] cmd_y = '0;
  logic             cmd_cin = 1'b0;
  logic [WIDTH-1:0] alu_x, alu_y, alu_f;
  logic [1:0]       alu_s;
  logic             alu_cin, alu_cout;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_f;
  logic             res_cout;
  logic [1:0]       res_s;
`ifdef ALU_ISSUE_STATS_EN
  logic [7:0]       op_count;
`endif

  alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_s     (cmd_s),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_cin   (cmd_cin),
    .alu_x     (alu_x),
    .alu_y     (alu_y),
    .alu_s     (alu_s),
    .alu_cin   (alu_cin),
    .alu_f     (alu_f),
    .alu_cout  (alu_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_f     (res_f),
    .res_cout  (res_cout),
    .res_s     (res_s)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]       s;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c;
  } cmd_rec_t;

  typedef struct {
    logic [1:0]       s;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             c;
    logic [WIDTH-1:0] ef;
    logic             ec;
  } vec_t;

  // Bench ALU: 0 add, 1 subtract (x + ~y + cin), 2 and, 3 xor (cout = cin).
  function automatic logic [WIDTH:0] alu_ref(input logic [1:0] s, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y, input logic c);
    int r;
    int m;
    m = (1 << WIDTH) - 1;
    case (s)
      2'd0:    r = int'(x) + int'(y) + int'(c);
      2'd1:    r = int'(x) + (~int'(y) & m) + int'(c);
      2'd2:    r = int'(x & y);
      default: r = int'(x ^ y) + (int'(c) << WIDTH);
    endcase
    return r[WIDTH:0];
  endfunction

  assign {alu_cout, alu_f} = alu_ref(alu_s, alu_x, alu_y, alu_cin);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_cmd(input cmd_rec_t c);
    cmd_s   = c.s;
    cmd_x   = c.x;
    cmd_y   = c.y;
    cmd_cin = c.c;
  endtask

  // All tasks start and end at a falling edge.
  task automatic do_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_res(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, " res_valid within bound"}, 32'(ok), 32'd1);
  endtask

  task automatic push_one(input cmd_rec_t c);
    drive_cmd(c);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  function automatic cmd_rec_t mk(input int k);
    cmd_rec_t c;
    c.s = 2'(k);
    c.x = WIDTH'(k * 5 + 3);
    c.y = WIDTH'(k * 7 + 1);
    c.c = k[0];
    return c;
  endfunction

  vec_t     tbl[7];
  cmd_rec_t exp_q[$];
  cmd_rec_t fill[6];
  cmd_rec_t cr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH:0] e;
    logic [9:0]     snap;
    int             last_hs;
    int             hs_cnt;
    int             spurious;
    bit             prev_hold;
    int             pv, pr;

    tbl[0] = '{s:2'd0, x:5'b10010, y:5'b00010, c:1'b0, ef:5'd20, ec:1'b0};
    tbl[1] = '{s:2'd0, x:5'd31,    y:5'd1,     c:1'b0, ef:5'd0,  ec:1'b1};
    tbl[2] = '{s:2'd0, x:5'd15,    y:5'd15,    c:1'b1, ef:5'd31, ec:1'b0};
    tbl[3] = '{s:2'd1, x:5'd10,    y:5'd3,     c:1'b1, ef:5'd7,  ec:1'b1};
    tbl[4] = '{s:2'd1, x:5'd3,     y:5'd10,    c:1'b1, ef:5'd25, ec:1'b0};
    tbl[5] = '{s:2'd2, x:5'd22,    y:5'd15,    c:1'b0, ef:5'd6,  ec:1'b0};
    tbl[6] = '{s:2'd3, x:5'd22,    y:5'd15,    c:1'b1, ef:5'd25, ec:1'b1};

    @(negedge clk);
    do_reset();

    // Reset state
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset alu_*", 32'({alu_s, alu_x, alu_y, alu_cin}), 32'd0);
    chk("reset res_*", 32'({res_s, res_f, res_cout}), 32'd0);

    // Table: single command through an idle queue, latency and hold checks
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("v%0d cmd_ready", i), 32'(cmd_ready), 32'd1);
      cmd_s = tbl[i].s; cmd_x = tbl[i].x; cmd_y = tbl[i].y; cmd_cin = tbl[i].c;
      cmd_valid = 1'b1;
      @(negedge clk);                       // edge N
      cmd_valid = 1'b0;
      chk($sformatf("v%0d no res at N", i), 32'(res_valid), 32'd0);
      @(negedge clk);                       // edge N+1
      chk($sformatf("v%0d alu_x", i), 32'(alu_x), 32'(tbl[i].x));
      chk($sformatf("v%0d alu_y", i), 32'(alu_y), 32'(tbl[i].y));
      chk($sformatf("v%0d alu_s/cin", i), 32'({alu_s, alu_cin}), 32'({tbl[i].s, tbl[i].c}));
      chk($sformatf("v%0d no res at N+1", i), 32'(res_valid), 32'd0);
      @(negedge clk);                       // edge N+2
      chk($sformatf("v%0d res_valid N+2", i), 32'(res_valid), 32'd1);
      chk($sformatf("v%0d res_f", i), 32'(res_f), 32'(tbl[i].ef));
      chk($sformatf("v%0d res_cout", i), 32'(res_cout), 32'(tbl[i].ec));
      chk($sformatf("v%0d res_s", i), 32'(res_s), 32'(tbl[i].s));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk($sformatf("v%0d res_valid cleared", i), 32'(res_valid), 32'd0);
      chk($sformatf("v%0d res_f held", i), 32'(res_f), 32'(tbl[i].ef));
      chk($sformatf("v%0d alu_x held", i), 32'(alu_x), 32'(tbl[i].x));
    end

    // Stall in RESULT, fill FIFO behind it, refuse the extra push, then drain
    do_reset();
    for (int k = 0; k < 6; k++) fill[k] = mk(k + 1);
    push_one(fill[0]);
    wait_res("stall c0");
    snap = {res_valid, res_cout, res_s, res_f, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("stall hold %0d", i), 32'({res_valid, res_cout, res_s, res_f, 1'b0}), 32'(snap));
    end
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("fill ready before push %0d", k), 32'(cmd_ready), 32'd1);
      push_one(fill[k]);
    end
    chk("full after 4 pushes", 32'(cmd_ready), 32'd0);
    drive_cmd(fill[5]);
    cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("5th push refused", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    chk("stall hold after fill", 32'({res_valid, res_cout, res_s, res_f, 1'b0}), 32'(snap));
    res_ready = 1'b1;
    last_hs = 0;
    for (int k = 0; k < 5; k++) begin
      wait_res($sformatf("drain %0d", k));
      e = alu_ref(fill[k].s, fill[k].x, fill[k].y, fill[k].c);
      chk($sformatf("drain %0d res_f", k), 32'(res_f), 32'(e[WIDTH-1:0]));
      chk($sformatf("drain %0d res_cout/s", k), 32'({res_cout, res_s}), 32'({e[WIDTH], fill[k].s}));
      if (k > 0) chk($sformatf("drain %0d spacing", k), 32'(cyc - last_hs), 32'd2);
      last_hs = cyc;
      @(negedge clk);
    end
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid) spurious++;
      @(negedge clk);
    end
    chk("refused cmd never issued", 32'(spurious), 32'd0);
    res_ready = 1'b0;

    // Reset while in EXEC with three commands queued
    do_reset();
    cr = '{s:2'd1, x:5'd21, y:5'd9, c:1'b1};
    push_one(cr);
    wait_res("rst c0");
    for (int k = 1; k <= 4; k++) push_one(mk(k + 8));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("rst pre: in EXEC, alu_x", 32'(alu_x), 32'(mk(9).x));
    #2 rst = 1'b1;
    #1;
    chk("rst async cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst async res_valid", 32'(res_valid), 32'd0);
    chk("rst async alu_*", 32'({alu_s, alu_x, alu_y, alu_cin}), 32'd0);
    chk("rst async res_*", 32'({res_s, res_f, res_cout}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (res_valid) spurious++;
    end
    chk("no result after reset", 32'(spurious), 32'd0);
    cr = '{s:2'd0, x:5'd7, y:5'd9, c:1'b1};
    res_ready = 1'b0;
    push_one(cr);
    wait_res("post-rst");
    chk("post-rst res_f", 32'(res_f), 32'd17);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    // Randomized traffic against a queue-based reference
    do_reset();
    exp_q.delete();
    hs_cnt = 0;
    prev_hold = 1'b0;
    snap = '0;
    for (int t = 0; t < 900; t++) begin
      case ((t / 150) % 3)
        0:       begin pv = 80; pr = 25; end
        1:       begin pv = 30; pr = 90; end
        default: begin pv = 60; pr = 60; end
      endcase
      cmd_valid = ($urandom_range(99) < pv);
      cmd_s     = 2'($urandom);
      cmd_x     = WIDTH'($urandom);
      cmd_y     = WIDTH'($urandom);
      cmd_cin   = 1'($urandom);
      res_ready = ($urandom_range(99) < pr);
      #1;
`ifdef ALU_ISSUE_STATS_EN
      chk("rand op_count", 32'(op_count), 32'((hs_cnt > 255) ? 255 : hs_cnt));
`endif
      if (prev_hold)
        chk("rand result stable", 32'({res_valid, res_cout, res_s, res_f, 1'b0}), 32'(snap));
      if (exp_q.size() < DEPTH)
        chk("rand cmd_ready with room", 32'(cmd_ready), 32'd1);
      else if (exp_q.size() == DEPTH + 1)
        chk("rand cmd_ready when full", 32'(cmd_ready), 32'd0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand unexpected result", 32'd1, 32'd0);
        end else begin
          cr = exp_q.pop_front();
          e  = alu_ref(cr.s, cr.x, cr.y, cr.c);
          chk("rand res", 32'({res_s, res_cout, res_f}), 32'({cr.s, e[WIDTH], e[WIDTH-1:0]}));
          hs_cnt++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        cr.s = cmd_s; cr.x = cmd_x; cr.y = cmd_y; cr.c = cmd_cin;
        exp_q.push_back(cr);
      end
      prev_hold = res_valid && !res_ready;
      snap = {res_valid, res_cout, res_s, res_f, 1'b0};
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int t = 0; t < 30; t++) begin
      #1;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("drain unexpected result", 32'd1, 32'd0);
        end else begin
          cr = exp_q.pop_front();
          e  = alu_ref(cr.s, cr.x, cr.y, cr.c);
          chk("drain res", 32'({res_s, res_cout, res_f}), 32'({cr.s, e[WIDTH], e[WIDTH-1:0]}));
          hs_cnt++;
        end
      end
      @(negedge clk);
    end
    chk("random model drained", 32'(exp_q.size()), 32'd0);
    chk("random enough results for wrap", 32'(hs_cnt > 2 * DEPTH + 1), 32'd1);
    res_ready = 1'b0;

`ifdef ALU_ISSUE_STATS_EN
    // Saturation of the handshake counter
    do_reset();
    hs_cnt = 0;
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    drive_cmd(mk(3));
    for (int t = 0; t < 1200 && hs_cnt < 260; t++) begin
      #1;
      if (res_valid && res_ready) hs_cnt++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("stats handshakes reached", 32'(hs_cnt), 32'd260);
    chk("stats op_count saturated", 32'(op_count), 32'd255);
    res_ready = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
